// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, flush, bubble insertion and stall counter.
// Define ID_EX_SKID_EN for a one-entry skid buffer with a registered in_ready.
module id_ex_pipe_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 9,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     rd1_in,
  input  logic [DATA_W-1:0]     rd2_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [REG_ADDR_W-1:0] rs_in,
  input  logic [REG_ADDR_W-1:0] rt_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [CTRL_W-1:0]     ctrl_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     rd1_out,
  output logic [DATA_W-1:0]     rd2_out,
  output logic [DATA_W-1:0]     imm_out,
  output logic [REG_ADDR_W-1:0] rs_out,
  output logic [REG_ADDR_W-1:0] rt_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int PAY_W = 4*DATA_W + 3*REG_ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}};

  logic [PAY_W-1:0]  pay_in_s;
  logic              accept_s;
  logic              drain_s;
  logic              in_ready_s;

  logic              valid_q, valid_d;
  logic [PAY_W-1:0]  pay_q, pay_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign pay_in_s = {pc_in, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in};
  assign {pc_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} = pay_q;
  assign ctrl_out  = ctrl_q;
  assign out_valid = valid_q;
  assign stall_cnt = cnt_q;
  assign drain_s   = valid_q && out_ready;
  assign accept_s  = in_valid && in_ready_s;

  // Stall counter: counts held cycles, frozen during flush, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (!flush && valid_q && !out_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

`ifdef ID_EX_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [PAY_W-1:0]  skid_pay_q, skid_pay_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q;

  assign in_ready_s = in_ready_q;
  assign in_ready   = in_ready_q;

  // Main/skid next state: a free main slot always refills from skid first to keep order.
  always_comb begin
    valid_d      = valid_q;
    pay_d        = pay_q;
    ctrl_d       = ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_pay_d   = skid_pay_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      valid_d      = 1'b0;
      ctrl_d       = CTRL_NOP;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = CTRL_NOP;
    end else if (!valid_q || drain_s) begin
      if (skid_valid_q) begin
        valid_d      = 1'b1;
        pay_d        = skid_pay_q;
        ctrl_d       = skid_ctrl_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = CTRL_NOP;
      end else if (accept_s) begin
        valid_d = 1'b1;
        pay_d   = pay_in_s;
        ctrl_d  = ctrl_in;
      end else begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_NOP;
      end
    end else if (accept_s) begin
      skid_valid_d = 1'b1;
      skid_pay_d   = pay_in_s;
      skid_ctrl_d  = ctrl_in;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // Skid storage and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_pay_q   <= {PAY_W{1'b0}};
      skid_ctrl_q  <= CTRL_NOP;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_pay_q   <= skid_pay_d;
      skid_ctrl_q  <= skid_ctrl_d;
      in_ready_q   <= !skid_valid_d;
    end
  end
`else
  assign in_ready_s = !valid_q || out_ready;
  assign in_ready   = in_ready_s;

  // Main register next state: flush beats accept beats drain; control zeroed on bubbles.
  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else if (accept_s) begin
      valid_d = 1'b1;
      pay_d   = pay_in_s;
      ctrl_d  = ctrl_in;
    end else if (drain_s) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else begin
      valid_d = valid_q;
    end
  end
`endif

  // Main stage registers and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= {PAY_W{1'b0}};
      ctrl_q  <= CTRL_NOP;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Scoreboard bench for id_ex_pipe_stage (CNT_W=4): directed stimulus pushes expected
// transfers, a negedge monitor pops and compares them; ID_EX_SKID_EN adds a skid ordering case.
module tb_id_ex_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] pc_in, rd1_in, rd2_in, imm_in, pc_out, rd1_out, rd2_out, imm_out;
  logic [4:0]  rs_in, rt_in, rd_in, rs_out, rt_out, rd_out;
  logic [8:0]  ctrl_in, ctrl_out;
  logic [3:0]  stall_cnt;

  typedef struct {
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [8:0]  ctrl;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  id_ex_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(9), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .ctrl_in(ctrl_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .ctrl_out(ctrl_out),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [8:0] ctrl);
    exp_t e;
    e.pc   = pc;
    e.rd1  = pc ^ 32'hA5A5_0000;
    e.rd2  = pc + 32'h0000_1000;
    e.imm  = ~pc;
    e.rs   = pc[6:2];
    e.rt   = pc[6:2] + 5'd1;
    e.rd   = pc[6:2] + 5'd2;
    e.ctrl = ctrl;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [8:0] ctrl);
    exp_t e;
    e = mk(pc, ctrl);
    in_valid = v;
    pc_in = e.pc; rd1_in = e.rd1; rd2_in = e.rd2; imm_in = e.imm;
    rs_in = e.rs; rt_in = e.rt; rd_in = e.rd; ctrl_in = e.ctrl;
  endtask

  task automatic send(input logic [31:0] pc, input logic [8:0] ctrl);
    drive(1'b1, pc, ctrl);
    q.push_back(mk(pc, ctrl));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop on every transfer, and hold the bubble guarantee whenever out_valid is low.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL xfer_unexpected: got pc=%0h expected no transfer", pc_out);
        end else begin
          e = q.pop_front();
          if (pc_out !== e.pc || rd1_out !== e.rd1 || rd2_out !== e.rd2 || imm_out !== e.imm ||
              rs_out !== e.rs || rt_out !== e.rt || rd_out !== e.rd || ctrl_out !== e.ctrl) begin
            n_err++;
            $display("FAIL xfer: got pc=%0h rd1=%0h rd2=%0h imm=%0h rs=%0h rt=%0h rd=%0h ctrl=%0h expected pc=%0h rd1=%0h rd2=%0h imm=%0h rs=%0h rt=%0h rd=%0h ctrl=%0h",
                     pc_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out, ctrl_out,
                     e.pc, e.rd1, e.rd2, e.imm, e.rs, e.rt, e.rd, e.ctrl);
          end
        end
      end
      if (!out_valid) chk("bubble_ctrl", {23'd0, ctrl_out}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 9'h000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ctrl", {23'd0, ctrl_out}, 32'd0);
    chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // streaming 0x0, 0x4, 0x8 back to back
    out_ready = 1'b1;
    send(32'h0, 9'h0A3); step(); chk("stream_v0", {31'd0, out_valid}, 32'd1);
    send(32'h4, 9'h05C); step(); chk("stream_v1", {31'd0, out_valid}, 32'd1);
    send(32'h8, 9'h111); step(); chk("stream_v2", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'hC, 9'h000); step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_pc_hold", pc_out, 32'h8);
    chk("drain_cnt", {28'd0, stall_cnt}, 32'd0);

    // stall three cycles on 0x10
    out_ready = 1'b0;
    send(32'h10, 9'h0C4); step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc_out, 32'h10);
`ifndef ID_EX_SKID_EN
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
`endif
    end
    chk("stall_cnt3", {28'd0, stall_cnt}, 32'd3);
    out_ready = 1'b1;
    #1;
`ifndef ID_EX_SKID_EN
    chk("ready_follows_out", {31'd0, in_ready}, 32'd1);
`endif
    step();
    chk("stall_drained", {31'd0, out_valid}, 32'd0);

    // flush with incoming all-ones control while 0x14 is held
    out_ready = 1'b0;
    send(32'h14, 9'h1E0); step();
    chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    q.delete();
    drive(1'b1, 32'h40, 9'h1FF);
    flush = 1'b1;
    #1;
`ifdef ID_EX_SKID_EN
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
`else
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
`endif
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ctrl", {23'd0, ctrl_out}, 32'd0);
    chk("flush_cnt", {28'd0, stall_cnt}, 32'd3);
    step();
    chk("flush_stays", {31'd0, out_valid}, 32'd0);

    // saturation: 20 more stall cycles on 0x30
    send(32'h30, 9'h0FF); step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("cnt_mid", {28'd0, stall_cnt}, 32'd8);
    repeat (15) step();
    chk("cnt_sat", {28'd0, stall_cnt}, 32'd15);
    chk("sat_pc", pc_out, 32'h30);
    out_ready = 1'b1; step(); out_ready = 1'b0;

`ifdef ID_EX_SKID_EN
    // 0x20 accepted into skid behind stalled 0x1C
    send(32'h1C, 9'h0A0); step();
    send(32'h20, 9'h050);
    #1;
    chk("skid_ready_pre", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("skid_ready_full", {31'd0, in_ready}, 32'd0);
    chk("skid_main_pc", pc_out, 32'h1C);
    out_ready = 1'b1;
    step();
    chk("skid_moved_valid", {31'd0, out_valid}, 32'd1);
    chk("skid_moved_pc", pc_out, 32'h20);
    chk("skid_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    chk("skid_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
`endif

    // asynchronous reset mid-transfer
    send(32'h50, 9'h1C3); step();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    q.delete();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_ctrl", {23'd0, ctrl_out}, 32'd0);
    chk("async_rst_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("async_rst_pc", pc_out, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
